// File: rtl/term_pkg.sv
// Shared constants, ASCII codes and state encoding for the terminal write controller.
package term_pkg;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int XW   = 7;
    localparam int YW   = 5;

    localparam logic [7:0] ASCII_ENTER = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [YW-1:0] next_row(input logic [YW-1:0] y);
        return (y == Y_LAST) ? '0 : y + YW'(1);
    endfunction

endpackage

// File: rtl/term_ctrl.sv
// Terminal write controller: cursor tracking, character/backspace writes,
// newline line-clear sequencing and circular scroll origin for the text buffer.
//
// state | meaning
// IDLE  | accepting characters, at most one buffer write per accept
// CLEAR | blanking the new cursor row one column per cycle, input stalled
module term_ctrl
    import term_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_char,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_data,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic [YW-1:0] top_row,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [YW-1:0] rows_used_q, rows_used_d;
    logic [XW-1:0] clr_left_q, clr_left_d;

    logic          in_ready_d, wr_en_d, busy_d;
    logic [XW-1:0] wr_x_d, cur_x_d;
    logic [YW-1:0] wr_y_d, cur_y_d, top_row_d;
    logic [7:0]    wr_data_d;

    logic accept, printable, newline;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rows_used_q <= YW'(1);
            clr_left_q  <= '0;
            in_ready    <= 1'b0;
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_data     <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            top_row     <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_used_q <= rows_used_d;
            clr_left_q  <= clr_left_d;
            in_ready    <= in_ready_d;
            wr_en       <= wr_en_d;
            wr_x        <= wr_x_d;
            wr_y        <= wr_y_d;
            wr_data     <= wr_data_d;
            cur_x       <= cur_x_d;
            cur_y       <= cur_y_d;
            top_row     <= top_row_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_used_d = rows_used_q;
        clr_left_d  = clr_left_q;
        in_ready_d  = in_ready;
        wr_en_d     = 1'b0;
        wr_x_d      = wr_x;
        wr_y_d      = wr_y;
        wr_data_d   = wr_data;
        cur_x_d     = cur_x;
        cur_y_d     = cur_y;
        top_row_d   = top_row;
        busy_d      = busy;
        accept      = in_valid && in_ready;
        printable   = (in_char >= ASCII_SP) && (in_char < ASCII_DEL);
        newline     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_x_d    = cur_x;
                        wr_y_d    = cur_y;
                        wr_data_d = in_char;
                        if (cur_x == X_LAST) newline = 1'b1;
                        else                 cur_x_d = cur_x + XW'(1);
                    end else if (in_char == ASCII_ENTER) begin
                        newline = 1'b1;
                    end else if (in_char == ASCII_BS && cur_x != '0) begin
                        cur_x_d   = cur_x - XW'(1);
                        wr_en_d   = 1'b1;
                        wr_x_d    = cur_x - XW'(1);
                        wr_y_d    = cur_y;
                        wr_data_d = 8'h00;
                    end
                end
                // Scroll only once every physical row holds text.
                if (newline) begin
                    cur_x_d    = '0;
                    cur_y_d    = next_row(cur_y);
                    if (rows_used_q < YW'(ROWS)) rows_used_d = rows_used_q + YW'(1);
                    else                         top_row_d   = next_row(top_row);
                    clr_left_d = XW'(COLS);
                    state_d    = CLEAR;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_left_q != '0) begin
                    wr_en_d    = 1'b1;
                    wr_x_d     = XW'(COLS) - clr_left_q;
                    wr_y_d     = cur_y;
                    wr_data_d  = 8'h00;
                    clr_left_d = clr_left_q - XW'(1);
                end else begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/term_ctrl.md
Name: term_ctrl

Overview:
- Terminal write controller that sits between the PS/2 ASCII stream and the text-mode character buffer.
- Accepts one ASCII character per handshake and maintains the cursor (column, row).
- Sequences all writes into the 70x30 character buffer: character writes, backspace erase, line clearing on newline.
- Drives a circular scroll origin (top_row) that the VGA read path adds to its row index.

Parameters:
- COLS, 70, characters per row.
- ROWS, 30, rows in buffer and on screen.
- XW, 7, column index width.
- YW, 5, row index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_char valid.
- in_ready  out  1  controller can accept a character.
- in_char  in  8  ASCII code.
- wr_en  out  1  buffer write strobe, one write per cycle.
- wr_x  out  XW  write column.
- wr_y  out  YW  write physical row.
- wr_data  out  8  write data.
- cur_x  out  XW  cursor column.
- cur_y  out  YW  cursor physical row.
- top_row  out  YW  physical row shown at the top of the screen.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, in_ready=0, wr_en=0, wr_x/wr_y/wr_data=0, cur_x=cur_y=0, top_row=0, rows_used=1, busy=0.
  - in_ready rises at the first posedge after reset deasserts.
  - Reset asserted mid-CLEAR aborts immediately; the partially cleared row is left as is.
- All outputs are registered. A character is accepted on a posedge with in_valid && in_ready; call that edge T.
- IDLE, in_ready=1:
  - Printable 0x20..0x7E:
    - At T+1: wr_en=1, wr_x=cur_x, wr_y=cur_y, wr_data=in_char.
    - If cur_x<COLS-1: cur_x+1 at T+1, state stays IDLE. Back-to-back accepts are allowed, 1 char/cycle.
    - If cur_x==COLS-1: wrap, i.e. newline after the write.
  - ENTER 0x0A: no character write; newline.
  - Backspace 0x08:
    - If cur_x>0: at T+1 cur_x-1, wr_en=1, wr_x=cur_x-1, wr_data=0x00.
    - If cur_x==0: no write, no cursor change. Backspace never moves up a row.
  - Any other code: discarded, no write, no state change.
- Newline, applied at T+1:
  - cur_x=0.
  - cur_y=(cur_y+1) mod ROWS, so 29 wraps to 0.
  - If rows_used<ROWS: rows_used+1. Otherwise top_row=(top_row+1) mod ROWS (scroll).
  - state=CLEAR, in_ready=0, busy=1.
- CLEAR:
  - Writes at T+2..T+COLS+1: wr_en=1, wr_data=0x00, wr_y=new cur_y, wr_x=0,1,..,COLS-1.
  - At T+COLS+2: state=IDLE, in_ready=1, busy=0, wr_en=0.
  - in_valid is ignored; the upstream holds the character.
- wr_en is 0 in every cycle not listed above.
- All index arithmetic is modulo its range. No value may ever exceed COLS-1 or ROWS-1.

Decomposition:
- Shared package term_pkg: constants COLS, ROWS, XW, YW, ASCII_ENTER=8'h0A, ASCII_BS=8'h08, ASCII_SP=8'h20, ASCII_DEL=8'h7F.
- term_pkg also holds the state enum {IDLE, CLEAR}.
- Single module, no sub-module. The clear counter and the cursor logic are small enough to stay inline.

Test Plan:
- Reset release, send 0x41 -> next cycle wr_en=1, (x,y)=(0,0), data 0x41; cur_x=1; in_ready stays 1.
- Send 0x41,0x42,0x43 on consecutive cycles -> three consecutive writes at x=0,1,2; cur_x=3; no stall.
- 70 printable chars from (0,0) -> last write at x=69. Next cycle cur=(0,1), in_ready=0. 70 writes of 0x00 to row 1, x 0..69. in_ready=1 exactly 72 cycles after the 70th accept.
- Cursor (5,0): send 0x0A -> no char write; row 1 cleared. Cursor (3,y): send 0x08 -> write 0x00 at x=2, cur_x=2. At x=0, 0x08 -> no write.
- 30 ENTERs from reset -> top_row stays 0 through the 29th. The 30th sets cur_y=0, top_row=1 and clears row 0. A 31st gives top_row=2.
- Assert reset during CLEAR at x=20 -> outputs go to reset values immediately, without a clock. After release, sending 0x41 writes it at (0,0).
